// File: rtl/vx_csa_accum_pkg.sv
// ---------------------------------------------------------------------------
// vx_csa_accum_pkg
//   Shared definitions for the carry-save accumulator:
//     - group FSM state encodings
//     - compression-tree geometry helpers (operand count per level, level
//       count, and placement of pipeline register slices between levels)
//   No ports; imported by vx_csa_accum and vx_csa_accum_stage.
// ---------------------------------------------------------------------------
package vx_csa_accum_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   // Operand count after one compression level: every full group of four
   // becomes a pair, a remainder of three becomes a pair, a remainder of one
   // or two passes through untouched.
   function automatic int csa_next_cnt(input int n);
      int r;
      if (n <= 2) return n;
      r = n % 4;
      return 2 * (n / 4) + ((r == 3) ? 2 : r);
   endfunction

   // Operand count entering level lvl (lvl = 0 is the raw beat).
   function automatic int csa_cnt_at(input int n, input int lvl);
      int c;
      c = n;
      for (int i = 0; i < lvl; i++) c = csa_next_cnt(c);
      return c;
   endfunction

   // Number of levels needed to reduce n operands to a sum/carry pair.
   function automatic int csa_levels(input int n);
      int c;
      int l;
      c = n;
      l = 0;
      while (c > 2) begin
         c = csa_next_cnt(c);
         l++;
      end
      return l;
   endfunction

   // True when a register slice follows level k (1-based). Slices are spread
   // as evenly as integer division allows; with pipe >= 1 the last level is
   // always registered so the accumulate stage sees a registered pair.
   function automatic bit csa_slice_after(input int k, input int pipe, input int levels);
      if (levels == 0 || pipe <= 0) return 1'b0;
      return ((k * pipe) / levels) > (((k - 1) * pipe) / levels);
   endfunction

endpackage

// File: rtl/vx_csa_accum_stage.sv
// ---------------------------------------------------------------------------
// vx_csa_accum_stage
//   One purely combinational carry-save compression level. Groups of four
//   inputs go through a 4:2 compressor (two chained 3:2 adders), a leftover
//   group of three through a single 3:2, and one or two leftovers pass
//   through. All arithmetic is ACC_W bits wide; carries shifted out of the
//   MSB are dropped, which keeps the sum exact modulo 2^ACC_W.
//   Ports:
//     data_in   in   IN_CNT  x ACC_W   operands of this level
//     data_out  out  OUT_CNT x ACC_W   reduced operands
// ---------------------------------------------------------------------------
module vx_csa_accum_stage
   import vx_csa_accum_pkg::*;
#(
   parameter int IN_CNT  = 4,
   parameter int ACC_W   = 32,
   parameter int OUT_CNT = csa_next_cnt(IN_CNT)
) (
   input  logic [IN_CNT-1:0][ACC_W-1:0]  data_in,
   output logic [OUT_CNT-1:0][ACC_W-1:0] data_out
);

   localparam int G4  = IN_CNT / 4;
   localparam int REM = IN_CNT % 4;

   function automatic logic [ACC_W-1:0] maj(input logic [ACC_W-1:0] a,
                                            input logic [ACC_W-1:0] b,
                                            input logic [ACC_W-1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < G4; gi++) begin : c42_g
         logic [ACC_W-1:0] s1;
         logic [ACC_W-1:0] k1;
         assign s1 = data_in[4*gi] ^ data_in[4*gi+1] ^ data_in[4*gi+2];
         assign k1 = maj(data_in[4*gi], data_in[4*gi+1], data_in[4*gi+2]) << 1;
         assign data_out[2*gi]   = s1 ^ k1 ^ data_in[4*gi+3];
         assign data_out[2*gi+1] = maj(s1, k1, data_in[4*gi+3]) << 1;
      end

      if (REM == 3) begin : c32_g
         assign data_out[2*G4]   = data_in[4*G4] ^ data_in[4*G4+1] ^ data_in[4*G4+2];
         assign data_out[2*G4+1] = maj(data_in[4*G4], data_in[4*G4+1], data_in[4*G4+2]) << 1;
      end else begin : pass_g
         for (gi = 0; gi < REM; gi++) begin : p_g
            assign data_out[2*G4+gi] = data_in[4*G4+gi];
         end
      end
   endgenerate

endmodule

// File: rtl/vx_csa_accum.sv
// ---------------------------------------------------------------------------
// vx_csa_accum
//   Pipelined multi-beat carry-save accumulator. Each accepted beat of N
//   operands is registered, compressed to a sum/carry pair through a tree of
//   vx_csa_accum_stage levels (PIPE register slices spread across the tree),
//   folded into a redundant accumulator by one more 4:2 stage, and on the
//   group's last beat a single carry-propagate add produces the result.
//   Latency from beat acceptance cycle t to valid_out is t+PIPE+2.
//
//   Ports:
//     clk, reset             clock, synchronous active-high reset
//     valid_in/ready_in      beat handshake (ready_in = not stalled)
//     first_in, last_in      group delimiters of the beat
//     operands [N][W]        beat operands
//     valid_out/ready_out    result handshake, result held until accepted
//     result [ACC_W]         group sum modulo 2^ACC_W
//     beats_out [CNT_W]      beats in the group, saturating
//   Optional (macro CSA_ACCUM_PERF_EN):
//     perf_groups [32]       results handed off, wraps
//     perf_stalls [32]       cycles with valid_in while not ready, wraps
// ---------------------------------------------------------------------------
module vx_csa_accum
   import vx_csa_accum_pkg::*;
#(
   parameter int N      = 16,
   parameter int W      = 8,
   parameter int SIGNED = 0,
   parameter int PIPE   = 1,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   output logic                  ready_in,
   input  logic                  first_in,
   input  logic                  last_in,
   input  logic [N-1:0][W-1:0]   operands,
   output logic                  valid_out,
   input  logic                  ready_out,
   output logic [ACC_W-1:0]      result,
   output logic [CNT_W-1:0]      beats_out
`ifdef CSA_ACCUM_PERF_EN
   ,
   output logic [31:0]           perf_groups,
   output logic [31:0]           perf_stalls
`endif
);

   localparam int LEVELS = csa_levels(N);

   typedef struct packed {
      logic [ACC_W-1:0] sum;
      logic [ACC_W-1:0] carry;
   } csa_pair_t;

   // A held result that downstream has not taken freezes the whole pipe.
   logic stall;
   logic valid_out_reg;
   assign stall    = valid_out_reg & ~ready_out;
   assign ready_in = ~stall;

   // ---------------- input register ----------------
   logic                 in_valid_reg;
   logic                 in_first_reg;
   logic                 in_last_reg;
   logic [N-1:0][W-1:0]  in_ops_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         in_valid_reg <= 1'b0;
         in_first_reg <= 1'b0;
         in_last_reg  <= 1'b0;
         in_ops_reg   <= '0;
      end else if (!stall) begin
         in_valid_reg <= valid_in;
         in_first_reg <= first_in;
         in_last_reg  <= last_in;
         in_ops_reg   <= operands;
      end
   end

   // ---------------- operand extension ----------------
   logic [N-1:0][ACC_W-1:0] ext_ops;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : ext_g
         if (SIGNED != 0) begin : s_g
            assign ext_ops[gi] = {{(ACC_W-W){in_ops_reg[gi][W-1]}}, in_ops_reg[gi]};
         end else begin : u_g
            assign ext_ops[gi] = {{(ACC_W-W){1'b0}}, in_ops_reg[gi]};
         end
      end
   endgenerate

   // ---------------- compression tree ----------------
   logic [ACC_W-1:0] tree_s;
   logic [ACC_W-1:0] tree_c;
   logic             tree_valid;
   logic             tree_first;
   logic             tree_last;

   generate
      for (gi = 0; gi < LEVELS; gi++) begin : lvl_g
         localparam int IN_CNT  = csa_cnt_at(N, gi);
         localparam int OUT_CNT = csa_cnt_at(N, gi + 1);

         logic [IN_CNT-1:0][ACC_W-1:0]  d_in;
         logic [OUT_CNT-1:0][ACC_W-1:0] d_comb;
         logic [OUT_CNT-1:0][ACC_W-1:0] q_data;
         logic lvl_valid_in, lvl_first_in, lvl_last_in;
         logic lvl_valid, lvl_first, lvl_last;

         if (gi == 0) begin : src_g
            assign d_in         = ext_ops;
            assign lvl_valid_in = in_valid_reg;
            assign lvl_first_in = in_first_reg;
            assign lvl_last_in  = in_last_reg;
         end else begin : src_g
            assign d_in         = lvl_g[gi-1].q_data;
            assign lvl_valid_in = lvl_g[gi-1].lvl_valid;
            assign lvl_first_in = lvl_g[gi-1].lvl_first;
            assign lvl_last_in  = lvl_g[gi-1].lvl_last;
         end

         vx_csa_accum_stage #(
            .IN_CNT  (IN_CNT),
            .ACC_W   (ACC_W),
            .OUT_CNT (OUT_CNT)
         ) u_stage (
            .data_in  (d_in),
            .data_out (d_comb)
         );

         if (csa_slice_after(gi + 1, PIPE, LEVELS)) begin : slice_g
            always_ff @(posedge clk) begin
               if (reset) begin
                  lvl_valid <= 1'b0;
                  lvl_first <= 1'b0;
                  lvl_last  <= 1'b0;
                  q_data    <= '0;
               end else if (!stall) begin
                  lvl_valid <= lvl_valid_in;
                  lvl_first <= lvl_first_in;
                  lvl_last  <= lvl_last_in;
                  q_data    <= d_comb;
               end
            end
         end else begin : wire_g
            assign lvl_valid = lvl_valid_in;
            assign lvl_first = lvl_first_in;
            assign lvl_last  = lvl_last_in;
            assign q_data    = d_comb;
         end
      end

      if (LEVELS == 0) begin : tree_out_g
         assign tree_s     = ext_ops[0];
         assign tree_c     = ext_ops[1];
         assign tree_valid = in_valid_reg;
         assign tree_first = in_first_reg;
         assign tree_last  = in_last_reg;
      end else begin : tree_out_g
         assign tree_s     = lvl_g[LEVELS-1].q_data[0];
         assign tree_c     = lvl_g[LEVELS-1].q_data[1];
         assign tree_valid = lvl_g[LEVELS-1].lvl_valid;
         assign tree_first = lvl_g[LEVELS-1].lvl_first;
         assign tree_last  = lvl_g[LEVELS-1].lvl_last;
      end
   endgenerate

   // ---------------- accumulate stage ----------------
   logic [0:0]              state_reg;
   logic [0:0]              state_next;
   csa_pair_t               acc_reg;
   csa_pair_t               acc_next;
   logic [CNT_W-1:0]        cnt_reg;
   logic [CNT_W-1:0]        cnt_next;
   logic                    opening;
   logic [3:0][ACC_W-1:0]   acc_in;
   logic [1:0][ACC_W-1:0]   acc_out;
   logic [ACC_W-1:0]        cpa_sum;
   logic [ACC_W-1:0]        result_reg;
   logic [CNT_W-1:0]        beats_reg;

   // A first beat, or any beat arriving while no group is open, starts from
   // an empty accumulator; a first beat in ACCUM silently drops the partial.
   assign opening   = tree_first | (state_reg == ST_IDLE);
   assign acc_in[0] = opening ? '0 : acc_reg.sum;
   assign acc_in[1] = opening ? '0 : acc_reg.carry;
   assign acc_in[2] = tree_s;
   assign acc_in[3] = tree_c;

   vx_csa_accum_stage #(
      .IN_CNT  (4),
      .ACC_W   (ACC_W),
      .OUT_CNT (2)
   ) u_acc_stage (
      .data_in  (acc_in),
      .data_out (acc_out)
   );

   assign acc_next.sum   = acc_out[0];
   assign acc_next.carry = acc_out[1];
   assign cpa_sum        = acc_out[0] + acc_out[1];
   assign state_next     = tree_last ? ST_IDLE : ST_ACCUM;
   assign cnt_next       = opening ? CNT_W'(1)
                         : ((cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         valid_out_reg <= 1'b0;
         result_reg    <= '0;
         beats_reg     <= '0;
      end else if (!stall) begin
         if (tree_valid) begin
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
         end
         // Not stalled means any held result is being taken this cycle, so
         // a new last beat can replace it directly.
         if (tree_valid && tree_last) begin
            result_reg    <= cpa_sum;
            beats_reg     <= cnt_next;
            valid_out_reg <= 1'b1;
         end else if (ready_out) begin
            valid_out_reg <= 1'b0;
         end
      end
   end

   assign valid_out = valid_out_reg;
   assign result    = result_reg;
   assign beats_out = beats_reg;

`ifdef CSA_ACCUM_PERF_EN
   logic [31:0] perf_groups_reg;
   logic [31:0] perf_stalls_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_groups_reg <= '0;
         perf_stalls_reg <= '0;
      end else begin
         if (valid_out_reg && ready_out) perf_groups_reg <= perf_groups_reg + 32'd1;
         if (valid_in && stall)          perf_stalls_reg <= perf_stalls_reg + 32'd1;
      end
   end

   assign perf_groups = perf_groups_reg;
   assign perf_stalls = perf_stalls_reg;
`endif

endmodule
